// File: rtl/sar_adc_seq.sv
// Successive-approximation ADC sequencer: drives DAC trial codes and the analog mux,
// samples the comparator in CHECK and resolves WIDTH bits MSB-first, optionally scanning all channels.
module sar_adc_seq #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             scan_en,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_out,
  output logic [CH_W-1:0]  mux_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data,
  output logic [CH_W-1:0]  data_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSETTLE,
    S_SETBIT,
    S_WAIT,
    S_CHECK
  } state_t;

  localparam logic [WIDTH-1:0] MSB         = WIDTH'(1) << (WIDTH - 1);
  localparam logic [3:0]       SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]    NUM_CH_EXT  = (CH_W + 1)'(NUM_CH);

  state_t           state;
  logic [WIDTH-1:0] bit_mask;
  logic [3:0]       cnt;
  logic             scan_r;
  logic [CH_W:0]    ch_ext;
  logic [CH_W-1:0]  ch_start;
  logic [WIDTH-1:0] decided;
  logic             last_ch;

  always_comb begin
    ch_ext   = {1'b0, ch_sel};
    ch_start = (ch_ext < NUM_CH_EXT) ? ch_sel : '0;
    // Trial code with this cycle's comparator decision folded in.
    decided  = comp_in ? dac_out : (dac_out & ~bit_mask);
    last_ch  = (mux_sel == LAST_CH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dac_out  <= '0;
      mux_sel  <= '0;
      data     <= '0;
      data_ch  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_mask <= '0;
      cnt      <= '0;
      scan_r   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            scan_r   <= scan_en;
            mux_sel  <= scan_en ? '0 : ch_start;
            dac_out  <= '0;
            bit_mask <= MSB;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= (SETTLE > 0) ? S_MSETTLE : S_SETBIT;
          end
        end

        S_MSETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_SETBIT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_SETBIT: begin
          dac_out <= dac_out | bit_mask;
          cnt     <= '0;
          state   <= (SETTLE > 0) ? S_WAIT : S_CHECK;
        end

        S_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_CHECK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_CHECK: begin
          dac_out <= decided;
          if (!bit_mask[0]) begin
            bit_mask <= bit_mask >> 1;
            state    <= S_SETBIT;
          end else begin
            data    <= decided;
            data_ch <= mux_sel;
            done    <= 1'b1;
            if (!scan_r || last_ch) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              // Next scan channel restarts exactly as a fresh start would.
              mux_sel  <= mux_sel + 1'b1;
              dac_out  <= '0;
              bit_mask <= MSB;
              cnt      <= '0;
              state    <= (SETTLE > 0) ? S_MSETTLE : S_SETBIT;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Directed bench for sar_adc_seq: three parameterisations, each with an ideal comparator
// model (comp = Vin[mux_sel] >= dac_out), table-driven single conversions plus corner sequences.
module tb_sar_adc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       scan_en = 1'b0;
  logic [1:0] ch_sel = '0;
  int unsigned which = 0;
  bit         glitch_en = 1'b0;
  int         cur_c = -1;

  logic [15:0] vin_a [4];
  logic [15:0] vin_b [4];
  logic [15:0] vin_c [4];

  logic       start_a, start_b, start_c;
  logic       comp_a, comp_b, comp_c;
  logic [7:0] dac_a, data_a, dac_c, data_c;
  logic [9:0] dac_b, data_b;
  logic [1:0] mux_a, mux_b, mux_c, dch_a, dch_b, dch_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

  assign start_a = start && (which == 0);
  assign start_b = start && (which == 1);
  assign start_c = start && (which == 2);

  assign comp_a = (vin_a[mux_a] >= {8'd0, dac_a});
  assign comp_b = (vin_b[mux_b] >= {6'd0, dac_b});

  // Instance C sees an inverted comparator except in the cycles where CHECK is expected.
  logic in_check_c, model_c;
  assign model_c    = (vin_c[mux_c] >= {8'd0, dac_c});
  assign in_check_c = (cur_c >= 7) && (((cur_c - 7) % 5) == 0);
  assign comp_c     = (glitch_en && !in_check_c) ? ~model_c : model_c;

  sar_adc_seq #(.WIDTH(8), .NUM_CH(4), .SETTLE(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .scan_en(scan_en), .ch_sel(ch_sel),
    .comp_in(comp_a), .dac_out(dac_a), .mux_sel(mux_a), .busy(busy_a), .done(done_a),
    .data(data_a), .data_ch(dch_a));

  sar_adc_seq #(.WIDTH(10), .NUM_CH(3), .SETTLE(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .scan_en(scan_en), .ch_sel(ch_sel),
    .comp_in(comp_b), .dac_out(dac_b), .mux_sel(mux_b), .busy(busy_b), .done(done_b),
    .data(data_b), .data_ch(dch_b));

  sar_adc_seq #(.WIDTH(8), .NUM_CH(4), .SETTLE(3)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .scan_en(scan_en), .ch_sel(ch_sel),
    .comp_in(comp_c), .dac_out(dac_c), .mux_sel(mux_c), .busy(busy_c), .done(done_c),
    .data(data_c), .data_ch(dch_c));

  logic [31:0] dac_m, mux_m, data_m, dch_m;
  logic        busy_m, done_m;

  always_comb begin
    dac_m = '0; mux_m = '0; data_m = '0; dch_m = '0; busy_m = 1'b0; done_m = 1'b0;
    case (which)
      0: begin dac_m = 32'(dac_a); mux_m = 32'(mux_a); data_m = 32'(data_a);
               dch_m = 32'(dch_a); busy_m = busy_a; done_m = done_a; end
      1: begin dac_m = 32'(dac_b); mux_m = 32'(mux_b); data_m = 32'(data_b);
               dch_m = 32'(dch_b); busy_m = busy_b; done_m = done_b; end
      default: begin dac_m = 32'(dac_c); mux_m = 32'(mux_c); data_m = 32'(data_c);
               dch_m = 32'(dch_c); busy_m = busy_c; done_m = done_c; end
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  int nd;
  logic [31:0] gd [4];
  logic [31:0] gc [4];
  int          gl [4];
  logic        gb [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic record(input int c);
    if (done_m) begin
      if (nd < 4) begin
        gd[nd] = data_m; gc[nd] = dch_m; gl[nd] = c; gb[nd] = busy_m;
      end
      nd++;
    end
  endtask

  // c counts edges after the one that accepts start; done is expected at c == latency.
  task automatic run(input int unsigned w, input logic sc, input logic [1:0] ch, input int n_exp,
                     input int budget, input bit glitch, input bit chk_settle);
    @(posedge clk); #1;
    which = w; scan_en = sc; ch_sel = ch; start = 1'b1; glitch_en = glitch; cur_c = -1;
    @(posedge clk); #1;
    start = 1'b0; nd = 0;
    for (int c = 0; c < budget; c++) begin
      cur_c = c;
      if (chk_settle && c <= 3) begin
        check("settle_mux", mux_m, 32'(ch));
        check("settle_dac", dac_m, 32'h0);
      end
      if (chk_settle && c == 4) check("setbit_dac", dac_m, 32'h80);
      record(c);
      @(posedge clk); #1;
    end
    cur_c = -1; glitch_en = 1'b0;
    check("done_count", 32'(nd), 32'(n_exp));
  endtask

  typedef struct {
    logic [1:0] ch;
    logic [7:0] vin;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{2'd2, 8'hA5, 8'hA5, 2'd2};
    vecs[1] = '{2'd0, 8'h00, 8'h00, 2'd0};
    vecs[2] = '{2'd3, 8'hFF, 8'hFF, 2'd3};
    vecs[3] = '{2'd1, 8'h80, 8'h80, 2'd1};
    vecs[4] = '{2'd1, 8'h7F, 8'h7F, 2'd1};
    vecs[5] = '{2'd3, 8'h01, 8'h01, 2'd3};
    for (int i = 0; i < 4; i++) begin vin_a[i] = '0; vin_b[i] = '0; vin_c[i] = '0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_dac", dac_m, 0);  check("rst_mux", mux_m, 0);
    check("rst_data", data_m, 0); check("rst_dch", dch_m, 0);
    check("rst_busy", 32'(busy_m), 0); check("rst_done", 32'(done_m), 0);
    rst = 1'b0;

    // Single-channel conversions, WIDTH=8 SETTLE=0: done 16 cycles after start.
    for (int i = 0; i < 6; i++) begin
      vin_a[vecs[i].ch] = {8'd0, vecs[i].vin};
      run(0, 1'b0, vecs[i].ch, 1, 30, 1'b0, 1'b0);
      check("tbl_data", gd[0], 32'(vecs[i].exp_data));
      check("tbl_ch", gc[0], 32'(vecs[i].exp_ch));
      check("tbl_lat", 32'(gl[0]), 16);
      check("tbl_busy_end", 32'(busy_m), 0);
    end

    // Stray start mid-conversion is ignored.
    vin_a[2] = 16'h3C;
    @(posedge clk); #1;
    which = 0; scan_en = 1'b0; ch_sel = 2'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      record(c);
      @(posedge clk); #1;
    end
    check("stray_count", 32'(nd), 1);
    check("stray_data", gd[0], 32'h3C);
    check("stray_lat", 32'(gl[0]), 16);

    // Start held high: the next conversion begins one cycle after returning to IDLE.
    vin_a[1] = 16'h96;
    @(posedge clk); #1;
    ch_sel = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 20) start = 1'b0;
      record(c);
      @(posedge clk); #1;
    end
    check("held_count", 32'(nd), 2);
    check("held_lat0", 32'(gl[0]), 16);
    check("held_lat1", 32'(gl[1]), 33);
    check("held_data1", gd[1], 32'h96);

    // Reset five cycles into a conversion aborts it.
    vin_a[3] = 16'hE7;
    @(posedge clk); #1;
    ch_sel = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; nd = 0;
    for (int c = 0; c < 4; c++) begin record(c); @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_dac", dac_m, 0);  check("abort_mux", mux_m, 0);
    check("abort_data", data_m, 0); check("abort_dch", dch_m, 0);
    check("abort_busy", 32'(busy_m), 0); check("abort_done", 32'(done_m), 0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin record(c); @(posedge clk); #1; end
    check("abort_no_done", 32'(nd), 0);
    run(0, 1'b0, 2'd3, 1, 30, 1'b0, 1'b0);
    check("after_rst_data", gd[0], 32'hE7);
    check("after_rst_lat", 32'(gl[0]), 16);

    // WIDTH=10 SETTLE=1 NUM_CH=3: full-scale, zero, and out-of-range channel.
    vin_b[1] = 16'h3FF;
    run(1, 1'b0, 2'd1, 1, 45, 1'b0, 1'b0);
    check("b_ff_data", gd[0], 32'h3FF);
    check("b_ff_lat", 32'(gl[0]), 31);
    vin_b[1] = 16'h000;
    run(1, 1'b0, 2'd1, 1, 45, 1'b0, 1'b0);
    check("b_00_data", gd[0], 32'h000);
    check("b_00_lat", 32'(gl[0]), 31);
    vin_b[0] = 16'h2AA; vin_b[3] = 16'h111;
    run(1, 1'b0, 2'd3, 1, 45, 1'b0, 1'b0);
    check("b_oor_data", gd[0], 32'h2AA);
    check("b_oor_ch", gc[0], 0);

    // SETTLE=3 with comparator glitches outside CHECK.
    vin_c[1] = 16'h5B;
    run(2, 1'b0, 2'd1, 1, 60, 1'b1, 1'b1);
    check("c_data", gd[0], 32'h5B);
    check("c_lat", 32'(gl[0]), 43);
    vin_c[3] = 16'hC3;
    run(2, 1'b0, 2'd3, 1, 60, 1'b1, 1'b1);
    check("c_data2", gd[0], 32'hC3);
    check("c_ch2", gc[0], 3);

    // Scan all four channels.
    vin_a[0] = 16'h12; vin_a[1] = 16'h34; vin_a[2] = 16'h56; vin_a[3] = 16'h78;
    run(0, 1'b1, 2'd2, 4, 80, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("scan_data", gd[k], 32'(vin_a[k]));
      check("scan_ch", gc[k], 32'(k));
      check("scan_lat", 32'(gl[k]), 32'(16 * (k + 1)));
      check("scan_busy", 32'(gb[k]), (k < 3) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
